// File: rtl/ov7670_sccb_config_pkg.sv
// Shared constants, state encodings and helpers for the OV7670 SCCB register loader.
package ov7670_cfg_pkg;

   localparam logic [15:0] ROM_END   = 16'hFFFF;
   localparam logic [15:0] ROM_DELAY = 16'hFFF0;

   // Three 9-bit phases per write frame: ID byte, register address, register data.
   localparam int FRAME_BITS = 27;

   typedef enum logic [2:0] {
      CFG_IDLE,
      CFG_FETCH,
      CFG_DECODE,
      CFG_SEND,
      CFG_DELAY,
      CFG_DONE
   } cfg_state_t;

   typedef enum logic [1:0] {
      WM_IDLE,
      WM_START,
      WM_BIT,
      WM_STOP
   } wm_state_t;

   // The ninth bit of every phase is the slave's don't-care/ACK slot where SIOD is released.
   function automatic logic isAckBit(input logic [4:0] bitIdx);
      return (bitIdx == 5'd8) || (bitIdx == 5'd17) || (bitIdx == 5'd26);
   endfunction

endpackage

// File: rtl/ov7670_sccb_config_if.sv
// Control, ROM and SCCB pin bundle of the OV7670 configuration block.
interface ov7670_sccb_config_if;

   logic        start;
   logic [4:0]  rom_addr;
   logic [15:0] rom_dout;
   logic        sioc;
   logic        siod_o;
   logic        siod_oe;
   logic        busy;
   logic        done;

   modport master (
      input  start, rom_dout,
      output rom_addr, sioc, siod_o, siod_oe, busy, done
   );

   modport slave (
      output start, rom_dout,
      input  rom_addr, sioc, siod_o, siod_oe, busy, done
   );

endinterface

// File: rtl/ov7670_sccb_config_write_master.sv
// SCCB 3-phase write engine: START, ID/reg/data phases of 9 bits each, STOP.
// Every bus event happens on a quarter-bit tick; all pin levels come straight from flops.
module sccb_write_master
   import ov7670_cfg_pkg::*;
#(
   parameter int          CLK_FREQ_HZ  = 100_000_000,
   parameter int          SCCB_FREQ_HZ = 100_000,
   parameter logic [7:0]  DEV_ADDR     = 8'h42
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req,
   input  logic [7:0] reg_addr,
   input  logic [7:0] reg_data,
   output logic       busy,
   output logic       done,
   output logic       sioc,
   output logic       siod_o,
   output logic       siod_oe
);

   localparam int             Q      = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
   localparam int             QW     = (Q > 1) ? $clog2(Q) : 1;
   localparam logic [QW-1:0]  Q_LAST = QW'(Q - 1);

   wm_state_t                 r_state;
   logic [QW-1:0]             r_qCnt;
   logic [1:0]                r_quarter;
   logic [4:0]                r_bitIdx;
   logic [FRAME_BITS-1:0]     r_frame;
   logic                      r_sioc;
   logic                      r_siod;
   logic                      r_oe;
   logic                      r_done;

   wm_state_t                 w_state;
   logic [1:0]                w_quarter;
   logic [4:0]                w_bitIdx;
   logic                      w_sioc;
   logic                      w_siod;
   logic                      w_oe;
   logic                      w_done;
   logic                      w_load;
   logic                      w_tick;

   assign w_tick = (r_qCnt == Q_LAST);

   // Next state and the pin levels for the quarter being entered; within a bit the quarters are
   // SIOC low / data settle / SIOC high / SIOC high, so data only ever moves while SIOC is low.
   always_comb begin
      w_state   = r_state;
      w_quarter = r_quarter;
      w_bitIdx  = r_bitIdx;
      w_sioc    = r_sioc;
      w_siod    = r_siod;
      w_oe      = r_oe;
      w_done    = 1'b0;
      w_load    = 1'b0;
      case (r_state)
         WM_IDLE: begin
            w_sioc = 1'b1;
            w_siod = 1'b1;
            w_oe   = 1'b1;
            if (req) begin
               w_load    = 1'b1;
               w_state   = WM_START;
               w_quarter = 2'd0;
               w_bitIdx  = 5'd0;
               w_siod    = 1'b0;
            end
         end
         WM_START: begin
            if (w_tick) begin
               w_sioc = 1'b0;
               if (r_quarter == 2'd3) begin
                  w_state   = WM_BIT;
                  w_quarter = 2'd0;
                  w_bitIdx  = 5'd0;
                  w_oe      = 1'b1;
               end else begin
                  w_quarter = r_quarter + 2'd1;
               end
            end
         end
         WM_BIT: begin
            if (w_tick) begin
               if (r_quarter == 2'd3) begin
                  w_quarter = 2'd0;
                  w_sioc    = 1'b0;
                  if (r_bitIdx == 5'(FRAME_BITS - 1)) begin
                     w_state = WM_STOP;
                     w_oe    = 1'b1;
                  end else begin
                     w_bitIdx = r_bitIdx + 5'd1;
                     w_oe     = !isAckBit(r_bitIdx + 5'd1);
                  end
               end else begin
                  w_quarter = r_quarter + 2'd1;
                  case (r_quarter)
                     2'd0:    w_siod = isAckBit(r_bitIdx) ? 1'b1 : r_frame[5'd26 - r_bitIdx];
                     2'd1:    w_sioc = 1'b1;
                     default: ;
                  endcase
               end
            end
         end
         WM_STOP: begin
            if (w_tick) begin
               if (r_quarter == 2'd3) begin
                  w_state   = WM_IDLE;
                  w_quarter = 2'd0;
                  w_bitIdx  = 5'd0;
                  w_done    = 1'b1;
               end else begin
                  w_quarter = r_quarter + 2'd1;
                  case (r_quarter)
                     2'd0:    w_siod = 1'b0;
                     2'd1:    w_sioc = 1'b1;
                     default: w_siod = 1'b1;
                  endcase
               end
            end
         end
         default: w_state = WM_IDLE;
      endcase
   end

   // State, quarter-tick prescaler, frame shadow and registered pin levels.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= WM_IDLE;
         r_qCnt    <= '0;
         r_quarter <= 2'd0;
         r_bitIdx  <= 5'd0;
         r_frame   <= '0;
         r_sioc    <= 1'b1;
         r_siod    <= 1'b1;
         r_oe      <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_quarter <= w_quarter;
         r_bitIdx  <= w_bitIdx;
         r_sioc    <= w_sioc;
         r_siod    <= w_siod;
         r_oe      <= w_oe;
         r_done    <= w_done;
         if ((r_state == WM_IDLE) || w_tick) begin
            r_qCnt <= '0;
         end else begin
            r_qCnt <= r_qCnt + 1'b1;
         end
         if (w_load) begin
            r_frame <= {DEV_ADDR, 1'b1, reg_addr, 1'b1, reg_data, 1'b1};
         end
      end
   end

   assign busy    = (r_state != WM_IDLE);
   assign done    = r_done;
   assign sioc    = r_sioc;
   assign siod_o  = r_siod;
   assign siod_oe = r_oe;

endmodule

// File: rtl/ov7670_sccb_config.sv
// Walks a 32-entry register ROM and writes each {reg, data} word to the camera over SCCB.
// 16'hFFF0 inserts a millisecond pause, 16'hFFFF ends the list; the last address also ends it.
module ov7670_sccb_config
   import ov7670_cfg_pkg::*;
#(
   parameter int         CLK_FREQ_HZ  = 100_000_000,
   parameter int         SCCB_FREQ_HZ = 100_000,
   parameter int         DELAY_MS     = 10,
   parameter logic [7:0] DEV_ADDR     = 8'h42
) (
   input  logic                  clk,
   input  logic                  reset_n,
   ov7670_sccb_config_if.master  bus
);

   localparam int             DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
   localparam int             DW           = $clog2(DELAY_CYCLES + 1);
   localparam logic [DW-1:0]  DELAY_LAST   = DW'(DELAY_CYCLES - 1);

   cfg_state_t        r_state;
   logic [4:0]        r_romAddr;
   logic              r_fetchCnt;
   logic [DW-1:0]     r_delayCnt;
   logic              r_wmReq;
   logic [7:0]        r_regAddr;
   logic [7:0]        r_regData;

   cfg_state_t        w_state;
   logic [4:0]        w_romAddr;
   logic              w_fetchCnt;
   logic [DW-1:0]     w_delayCnt;
   logic              w_wmReq;
   logic              w_latch;
   logic              w_wmBusy;
   logic              w_wmDone;

   // Sequencer: fetch (address register + ROM latency), decode, then either write, pause or stop.
   // Moving past address 31 finishes the list rather than wrapping back to 0.
   always_comb begin
      w_state    = r_state;
      w_romAddr  = r_romAddr;
      w_fetchCnt = 1'b0;
      w_delayCnt = '0;
      w_wmReq    = 1'b0;
      w_latch    = 1'b0;
      case (r_state)
         CFG_IDLE: begin
            w_romAddr = 5'd0;
            if (bus.start) begin
               w_state = CFG_FETCH;
            end
         end
         CFG_FETCH: begin
            if (r_fetchCnt) begin
               w_state = CFG_DECODE;
            end else begin
               w_fetchCnt = 1'b1;
            end
         end
         CFG_DECODE: begin
            if (bus.rom_dout == ROM_END) begin
               w_state = CFG_DONE;
            end else if (bus.rom_dout == ROM_DELAY) begin
               w_state = CFG_DELAY;
            end else if (!w_wmBusy) begin
               w_latch = 1'b1;
               w_wmReq = 1'b1;
               w_state = CFG_SEND;
            end
         end
         CFG_SEND: begin
            if (w_wmDone) begin
               if (r_romAddr == 5'd31) begin
                  w_state = CFG_DONE;
               end else begin
                  w_romAddr = r_romAddr + 5'd1;
                  w_state   = CFG_FETCH;
               end
            end
         end
         CFG_DELAY: begin
            if (r_delayCnt == DELAY_LAST) begin
               if (r_romAddr == 5'd31) begin
                  w_state = CFG_DONE;
               end else begin
                  w_romAddr = r_romAddr + 5'd1;
                  w_state   = CFG_FETCH;
               end
            end else begin
               w_delayCnt = r_delayCnt + 1'b1;
            end
         end
         CFG_DONE: begin
            if (bus.start) begin
               w_romAddr = 5'd0;
               w_state   = CFG_FETCH;
            end
         end
         default: w_state = CFG_IDLE;
      endcase
   end

   // Sequencer registers, including the one-cycle write request and its latched operands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= CFG_IDLE;
         r_romAddr  <= 5'd0;
         r_fetchCnt <= 1'b0;
         r_delayCnt <= '0;
         r_wmReq    <= 1'b0;
         r_regAddr  <= 8'h00;
         r_regData  <= 8'h00;
      end else begin
         r_state    <= w_state;
         r_romAddr  <= w_romAddr;
         r_fetchCnt <= w_fetchCnt;
         r_delayCnt <= w_delayCnt;
         r_wmReq    <= w_wmReq;
         if (w_latch) begin
            r_regAddr <= bus.rom_dout[15:8];
            r_regData <= bus.rom_dout[7:0];
         end
      end
   end

   sccb_write_master #(
      .CLK_FREQ_HZ  (CLK_FREQ_HZ),
      .SCCB_FREQ_HZ (SCCB_FREQ_HZ),
      .DEV_ADDR     (DEV_ADDR)
   ) u_writeMaster (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (r_wmReq),
      .reg_addr (r_regAddr),
      .reg_data (r_regData),
      .busy     (w_wmBusy),
      .done     (w_wmDone),
      .sioc     (bus.sioc),
      .siod_o   (bus.siod_o),
      .siod_oe  (bus.siod_oe)
   );

   assign bus.rom_addr = r_romAddr;
   assign bus.busy     = (r_state == CFG_FETCH) || (r_state == CFG_DECODE) ||
                         (r_state == CFG_SEND)  || (r_state == CFG_DELAY);
   assign bus.done     = (r_state == CFG_DONE);

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Scoreboard bench for ov7670_sccb_config: expected SCCB frames are queued when a sequence is
// started, and a bus monitor decodes frames off SIOC/SIOD and checks them against the queue.
module tb_ov7670_sccb_config;

   // Scaled-down clocking keeps the run short: Q = 1e6/(4*62500) = 4 cycles, pause = 1000 cycles.
   localparam int CLK_HZ    = 1_000_000;
   localparam int SCCB_HZ   = 62_500;
   localparam int DLY_MS    = 1;
   localparam int Q         = 4;
   localparam int DELAY_CYC = 1000;
   localparam int FRAME_CYC = 116 * Q;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   ov7670_sccb_config_if bus();

   ov7670_sccb_config #(
      .CLK_FREQ_HZ  (CLK_HZ),
      .SCCB_FREQ_HZ (SCCB_HZ),
      .DELAY_MS     (DLY_MS),
      .DEV_ADDR     (8'h42)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Registered ROM model with one cycle of read latency.
   logic [15:0] romMem [32];
   always @(posedge clk) bus.rom_dout <= romMem[bus.rom_addr];

   int          errors = 0;
   int          checks = 0;
   int          cycle  = 0;
   logic [23:0] expQ [$];
   int          startLog [$];
   int          framesDone = 0;

   bit          inFrame   = 1'b0;
   int          bitsSeen  = 0;
   logic [26:0] shiftReg  = '0;
   int          frameStart = 0;
   int          highStart  = 0;
   bit          highValid  = 1'b0;
   int          violations = 0;
   logic        prevS = 1'b1;
   logic        prevD = 1'b1;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      checks++;
      if (actual < lo || actual > hi) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   task automatic applyStimulus();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) break;
      end
      checkOutput("done reached within budget", bus.done, 1);
   endtask

   // Bus monitor: decodes START, 27 bits sampled on SIOC rising edges and STOP, then scores the frame.
   always @(negedge clk) begin : monitor
      logic        s;
      logic        d;
      logic        oe;
      logic [23:0] expFrame;
      s  = bus.sioc;
      d  = bus.siod_o;
      oe = bus.siod_oe;
      if (!reset_n) begin
         inFrame  = 1'b0;
         bitsSeen = 0;
      end else if (!inFrame) begin
         if (prevS && s && prevD && !d) begin
            inFrame    = 1'b1;
            bitsSeen   = 0;
            shiftReg   = '0;
            frameStart = cycle;
            highValid  = 1'b0;
            violations = 0;
            startLog.push_back(cycle);
         end
      end else begin
         if (!prevS && s) begin
            if (bitsSeen < 27) begin
               shiftReg = {shiftReg[25:0], d};
               bitsSeen++;
               if (bitsSeen % 9 == 0) checkOutput("ninth bit siod_oe", oe, 0);
               else                   checkOutput("data bit siod_oe", oe, 1);
            end
            highStart = cycle;
            highValid = 1'b1;
         end else if (prevS && !s) begin
            if (highValid) checkRange("sioc high width", cycle - highStart, 2 * Q, 2 * Q);
            highValid = 1'b0;
         end else if (prevS && s && (prevD != d)) begin
            if (bitsSeen == 27 && d) begin
               inFrame = 1'b0;
               framesDone++;
               checkOutput("siod stable while sioc high", violations, 0);
               // The STOP rise opens the last quarter of the frame.
               checkRange("frame length", cycle - frameStart + Q, FRAME_CYC - 2, FRAME_CYC + 2);
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected frame: got 0x%0h, expected none",
                           {shiftReg[26:19], shiftReg[17:10], shiftReg[8:1]});
               end else begin
                  expFrame = expQ.pop_front();
                  checkOutput("frame bytes", {8'h00, shiftReg[26:19], shiftReg[17:10], shiftReg[8:1]},
                              {8'h00, expFrame});
               end
            end else begin
               violations++;
            end
         end
      end
      prevS = s;
      prevD = d;
   end

   initial begin
      int f0;
      int lowCount;
      int starts0;
      int n;
      bus.start = 1'b0;
      for (int i = 0; i < 32; i++) romMem[i] = 16'hFFFF;

      // Reset state, observed while reset is still asserted.
      #3 reset_n = 1'b0;
      #1;
      checkOutput("reset busy", bus.busy, 0);
      checkOutput("reset done", bus.done, 0);
      checkOutput("reset rom_addr", bus.rom_addr, 0);
      checkOutput("reset sioc", bus.sioc, 1);
      checkOutput("reset siod_o", bus.siod_o, 1);
      checkOutput("reset siod_oe", bus.siod_oe, 1);
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Write, pause, write, end marker; stray start pulses while busy must be ignored.
      $display("[TB] sequence with delay entry");
      romMem[0] = 16'h1280;
      romMem[1] = 16'hFFF0;
      romMem[2] = 16'h3A04;
      romMem[3] = 16'hFFFF;
      startLog.delete();
      f0 = framesDone;
      expQ.push_back(24'h42_12_80);
      expQ.push_back(24'h42_3A_04);
      applyStimulus();
      checkOutput("busy after start", bus.busy, 1);
      checkOutput("done after start", bus.done, 0);
      repeat (100) @(negedge clk);
      applyStimulus();
      repeat (600) @(negedge clk);
      applyStimulus();
      waitDone(5000);
      checkOutput("rom_addr at end marker", bus.rom_addr, 3);
      checkOutput("busy when done", bus.busy, 0);
      checkOutput("frames in delay sequence", framesDone - f0, 2);
      checkOutput("frame starts logged", startLog.size(), 2);
      // Frame, then 2 fetch + decode, 1000 pause cycles, 2 fetch + decode + req, +1 into START.
      if (startLog.size() == 2)
         checkRange("start-to-start gap", startLog[1] - startLog[0],
                    FRAME_CYC + DELAY_CYC + 6, FRAME_CYC + DELAY_CYC + 10);

      // A start from DONE reruns the whole list and clears done immediately.
      $display("[TB] restart from done");
      f0 = framesDone;
      expQ.push_back(24'h42_12_80);
      expQ.push_back(24'h42_3A_04);
      applyStimulus();
      checkOutput("done cleared on restart", bus.done, 0);
      checkOutput("busy on restart", bus.busy, 1);
      waitDone(5000);
      checkOutput("rom_addr after restart", bus.rom_addr, 3);
      checkOutput("frames in restart", framesDone - f0, 2);

      // No end marker: all 32 entries are written and the address does not wrap.
      $display("[TB] full ROM without end marker");
      for (int i = 0; i < 32; i++) romMem[i] = 16'h1234;
      f0 = framesDone;
      for (int i = 0; i < 32; i++) expQ.push_back(24'h42_12_34);
      applyStimulus();
      waitDone(20000);
      checkOutput("rom_addr at last entry", bus.rom_addr, 31);
      checkOutput("frames in full ROM", framesDone - f0, 32);
      repeat (600) @(negedge clk);
      checkOutput("no wrap frames", framesDone - f0, 32);
      checkOutput("done stays set", bus.done, 1);
      checkOutput("rom_addr holds", bus.rom_addr, 31);
      checkOutput("scoreboard drained", expQ.size(), 0);

      // Reset in the middle of a frame aborts it with the bus idle at once.
      $display("[TB] reset during a frame");
      f0 = framesDone;
      applyStimulus();
      n = 0;
      while (!(inFrame && bitsSeen == 5) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reached frame bit 5", (inFrame && bitsSeen == 5), 1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("abort sioc", bus.sioc, 1);
      checkOutput("abort siod_o", bus.siod_o, 1);
      checkOutput("abort siod_oe", bus.siod_oe, 1);
      checkOutput("abort busy", bus.busy, 0);
      checkOutput("abort rom_addr", bus.rom_addr, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      starts0  = startLog.size();
      lowCount = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.sioc !== 1'b1 || bus.busy !== 1'b0) lowCount++;
      end
      checkOutput("bus quiet after reset", lowCount, 0);
      checkOutput("no frame after reset", startLog.size() - starts0, 0);
      checkOutput("aborted frame not completed", framesDone - f0, 0);

      // Recovery: a fresh start after the abort runs normally from address 0.
      $display("[TB] start after abort");
      romMem[0] = 16'h1280;
      romMem[1] = 16'hFFFF;
      f0 = framesDone;
      expQ.push_back(24'h42_12_80);
      applyStimulus();
      waitDone(3000);
      checkOutput("rom_addr after recovery", bus.rom_addr, 1);
      checkOutput("frames after recovery", framesDone - f0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ov7670_sccb_config.md
OV7670_SCCB_CONFIG -- requirements
Module: ov7670_sccb_config

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- SCCB_FREQ_HZ, 100_000, SIOC bit rate.
- DELAY_MS, 10, length of the delay that a 16'hFFF0 ROM word inserts.
- DEV_ADDR, 8'h42, SCCB write ID byte.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that starts the configuration sequence.
- rom_addr, out, 5, address to the config ROM.
- rom_dout, in, 16, ROM word {reg[15:8], data[7:0]}, registered, 1-cycle read latency.
- sioc, out, 1, SCCB clock.
- siod_o, out, 1, SCCB data value.
- siod_oe, out, 1, SIOD drive enable; 0 releases the line (pulled up externally).
- busy, out, 1, sequence in progress.
- done, out, 1, sequence complete; sticky.

Function
REQ-003 Top FSM states: IDLE, FETCH, DECODE, SEND, DELAY, DONE.
REQ-004 IDLE: rom_addr=0; start=1 -> FETCH, busy=1, done=0.
REQ-005 FETCH: holds rom_addr for exactly 2 cycles (address register + ROM latency), then -> DECODE.
REQ-006 DECODE, rom_dout==16'hFFFF: -> DONE.
REQ-007 DECODE, rom_dout==16'hFFF0: -> DELAY.
REQ-008 DECODE, any other word: latch reg/data into the write master, pulse its req for 1 cycle, -> SEND.
REQ-009 SEND: waits for the write master's done pulse, then increments rom_addr -> FETCH.
REQ-010 DELAY: counts CLK_FREQ_HZ/1000*DELAY_MS cycles (1_000_000 at defaults), then increments rom_addr -> FETCH.
REQ-011 Address boundary: an increment from rom_addr=31 -> DONE; no wrap to 0.
REQ-012 DONE: busy=0, done=1; start=1 -> restarts at addr 0 exactly as from IDLE.
REQ-013 start while busy=1 is ignored.
REQ-014 Write master ticks at quarter-bit intervals: Q = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) cycles (250 at defaults); counter width is $clog2(Q).
REQ-015 Bus-idle level: sioc=1, siod_oe=1, siod_o=1.
REQ-016 Transaction frame: START, three 9-bit phases (DEV_ADDR, reg, data), STOP.
REQ-017 Phase bits are 8 bits MSB first plus a ninth don't-care bit.
REQ-018 START: siod_o falls with sioc=1, held Q; then sioc falls.
REQ-019 Per bit: data changes only while sioc=0. Sequence: sioc low Q, data settle Q, sioc high 2Q, sioc low. One bit = 4Q.
REQ-020 Ninth bit: siod_oe=0 for the whole bit; the ACK level is not sampled.
REQ-021 STOP: siod_o=0 with sioc low; sioc rises and is held Q; then siod_o rises and is held Q; then done pulses for 1 cycle.
REQ-022 Transaction length: 4Q start + 108Q bits + 4Q stop = 116Q cycles, +/-2 cycles.
REQ-023 sioc and siod_o are driven directly from flops (glitch-free).

Reset
REQ-024 reset_n low, asynchronously: FSM=IDLE, rom_addr=0, busy=0, done=0, sioc=1, siod_o=1, siod_oe=1; all counters cleared.
REQ-025 Reset mid-transaction aborts the transfer without a STOP; after reset release the bus stays idle until the next start.

Structure
REQ-026 Package ov7670_cfg_pkg holds:
- ROM_END=16'hFFFF;
- ROM_DELAY=16'hFFF0;
- the top FSM state enum;
- the write-master state enum (IDLE, START, BIT, STOP).
REQ-027 One sub-module, sccb_write_master:
- inputs clk, reset_n, req, reg_addr[7:0], reg_data[7:0];
- outputs busy, done, sioc, siod_o, siod_oe.
- Its req is ignored while its busy=1.

Verification
REQ-028 ROM model {0:12_80, 1:FF_F0, 2:3A_04, 3:FF_FF}; start -> first frame decodes 42/12/80, then a 1_000_000-cycle gap, then frame 42/3A/04, then done=1 and rom_addr=3.
REQ-029 Single frame timing: sioc high periods are 500 cycles; frame length is 29000 +/-2 cycles; siod_oe=0 during bits 9, 18 and 27.
REQ-030 ROM returns 12_34 at all 32 addresses -> exactly 32 frames, then done=1, with no wrap to addr 0.
REQ-031 reset_n low at frame bit 5 -> sioc=1, siod_o=1, busy=0 within the same cycle; no further activity until start.
REQ-032 start pulses during busy -> ignored; start in DONE -> a full second sequence runs and done clears at its start.
REQ-033 Protocol checker: siod_o never changes while sioc=1, except at START and STOP.
